// File: rtl/tx_os_pkg.sv
// Shared ordered-set type codes, scheduler FSM states and the default SKP interval.
// No timing; backpressure not applicable.
package tx_os_pkg;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_TS1  = 3'd1,
    OS_TS2  = 3'd2,
    OS_SKP  = 3'd3,
    OS_EIOS = 3'd4,
    OS_FTS  = 3'd5
  } os_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_START,
    ST_SEND
  } skp_state_t;

  localparam int SKP_INTERVAL_DEFAULT = 1180;

endpackage

// File: rtl/skp_interval_counter.sv
// SKP interval timer with saturating pending-request count and sticky overflow.
// Latency: due is combinational on the wrap cycle, pending updates 1 cycle later; no backpressure.
module skp_interval_counter #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_WIDTH    = 11,
  parameter int MAX_PENDING  = 3
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       dec,
  input  logic       clr,
  output logic       due,
  output logic [1:0] pending,
  output logic       overflow
);

  localparam logic [CNT_WIDTH-1:0] LAST     = CNT_WIDTH'(SKP_INTERVAL - 1);
  localparam logic [1:0]           MAX_PEND = 2'(MAX_PENDING);

  logic [CNT_WIDTH-1:0] cnt;

  assign due = enable && (cnt == LAST);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!enable || due) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  // A due and a decrement in the same cycle cancel each other out.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      pending  <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (due && pending == MAX_PEND) begin
        overflow <= 1'b1;
      end
      if (clr) begin
        pending <= 2'd0;
      end else if (due && !dec && pending != MAX_PEND) begin
        pending <= pending + 2'd1;
      end else if (dec && !due && pending != 2'd0) begin
        pending <= pending - 2'd1;
      end
    end
  end

endmodule

// File: rtl/tx_skp_scheduler.sv
// Steers the TX mux to the OS generator at packet boundaries to emit pending SKP ordered sets.
// Latency: 2 cycles from pending with a free boundary to os_start; os_busy stalls in HOLD, pkt_active stalls in IDLE.
module tx_skp_scheduler
  import tx_os_pkg::*;
#(
  parameter int SKP_INTERVAL = SKP_INTERVAL_DEFAULT,
  parameter int CNT_WIDTH    = 11,
  parameter int MAX_PENDING  = 3
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       pkt_active,
  input  logic       os_busy,
  input  logic       os_finish,
  output logic       os_start,
  output logic [2:0] os_type,
  output logic       mux_sel,
  output logic       hold_fifo,
  output logic [1:0] skp_pending,
  output logic       skp_overflow
);

  skp_state_t state, state_nxt;
  logic       due, dec, clr;
  logic [2:0] post_pend;

  skp_interval_counter #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .CNT_WIDTH   (CNT_WIDTH),
    .MAX_PENDING (MAX_PENDING)
  ) u_interval (
    .pclk    (pclk),
    .reset_n (reset_n),
    .enable  (enable),
    .dec     (dec),
    .clr     (clr),
    .due     (due),
    .pending (skp_pending),
    .overflow(skp_overflow)
  );

  // Pending count as it will stand after this cycle's finish (and any coincident due).
  assign post_pend = {1'b0, skp_pending} + {2'b00, due} - 3'd1;

  always_comb begin
    state_nxt = state;
    dec       = 1'b0;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!enable) begin
          clr = 1'b1;
        end else if (skp_pending != 2'd0 && !pkt_active) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!enable) begin
          clr       = 1'b1;
          state_nxt = ST_IDLE;
        end else if (!os_busy) begin
          state_nxt = ST_START;
        end
      end
      ST_START: state_nxt = ST_SEND;
      ST_SEND: begin
        if (os_finish) begin
          dec = 1'b1;
          if (enable && post_pend != 3'd0) begin
            state_nxt = ST_START;
          end else begin
            clr       = !enable;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they describe.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      os_start  <= 1'b0;
      os_type   <= OS_NONE;
      mux_sel   <= 1'b0;
      hold_fifo <= 1'b0;
    end else begin
      state     <= state_nxt;
      os_start  <= (state_nxt == ST_START);
      os_type   <= (state_nxt != ST_IDLE) ? OS_SKP : OS_NONE;
      mux_sel   <= (state_nxt != ST_IDLE);
      hold_fifo <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// Bench for tx_skp_scheduler: directed scenarios plus randomized traffic against a behavioural model.
module tb_tx_skp_scheduler;
  import tx_os_pkg::*;

  localparam int N    = 16;
  localparam int MAXP = 3;

  logic       pclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       pkt_active = 1'b0;
  logic       os_busy = 1'b0;
  logic       os_finish = 1'b0;
  logic       os_start;
  logic [2:0] os_type;
  logic       mux_sel;
  logic       hold_fifo;
  logic [1:0] skp_pending;
  logic       skp_overflow;

  int checks = 0;
  int failures = 0;
  int fin_cd = 0;
  int fin_delay = 4;
  bit rnd_mode = 1'b0;

  always #5 pclk = ~pclk;

  tx_skp_scheduler #(
    .SKP_INTERVAL(N),
    .CNT_WIDTH   (11),
    .MAX_PENDING (MAXP)
  ) dut (
    .pclk        (pclk),
    .reset_n     (reset_n),
    .enable      (enable),
    .pkt_active  (pkt_active),
    .os_busy     (os_busy),
    .os_finish   (os_finish),
    .os_start    (os_start),
    .os_type     (os_type),
    .mux_sel     (mux_sel),
    .hold_fifo   (hold_fifo),
    .skp_pending (skp_pending),
    .skp_overflow(skp_overflow)
  );

  // Reference model: elapsed enabled cycles, an integer pending count, and whether the
  // scheduler owns the mux / has an ordered set in flight / is pulsing start this cycle.
  int m_elapsed = 0;
  int m_pend = 0;
  bit m_ovf = 0, m_owns = 0, m_fly = 0, m_start = 0;

  always @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      m_elapsed = 0; m_pend = 0; m_ovf = 0; m_owns = 0; m_fly = 0; m_start = 0;
    end else begin : model_step
      bit expired, done;
      int p;
      expired   = enable && (m_elapsed % N == N - 1);
      m_elapsed = enable ? m_elapsed + 1 : 0;
      done      = m_owns && m_fly && !m_start && os_finish;
      if (expired && m_pend == MAXP) m_ovf = 1;
      p = m_pend + (expired ? 1 : 0) - (done ? 1 : 0);
      if (p > MAXP) p = MAXP;
      if (!m_owns) begin
        if (!enable) p = 0;
        else if (m_pend > 0 && !pkt_active) m_owns = 1;
      end else if (!m_fly) begin
        if (!enable) begin m_owns = 0; p = 0; end
        else if (!os_busy) begin m_fly = 1; m_start = 1; end
      end else if (m_start) begin
        m_start = 0;
      end else if (os_finish) begin
        if (enable && p > 0) m_start = 1;
        else begin m_owns = 0; m_fly = 0; if (!enable) p = 0; end
      end
      m_pend = p;
    end
  end

  // Advance to the next sampling point and act as the OS generator's finish responder.
  task automatic step_cycle();
    @(negedge pclk);
    os_finish = 1'b0;
    if (fin_cd > 0) begin
      fin_cd--;
      if (fin_cd == 0) os_finish = 1'b1;
    end
    if (os_start) fin_cd = rnd_mode ? int'($urandom_range(1, 6)) : fin_delay;
    if (rnd_mode && fin_cd == 0 && !os_finish && $urandom_range(0, 49) == 0) os_finish = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0; enable = 1'b0; pkt_active = 1'b0; os_busy = 1'b0; os_finish = 1'b0;
    fin_cd = 0; fin_delay = 4; rnd_mode = 1'b0;
    repeat (2) @(negedge pclk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      step_cycle();
      obs = {os_start, os_type, mux_sel, hold_fifo, skp_pending, skp_overflow};
      checks++;
      if (obs !== 9'd0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: outputs=%b expected=%b", i, obs, 9'd0);
      end
    end
  endtask

  task automatic test_interval();
    int first = -1, second = -1;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step_cycle();
      if (os_start) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (i == 15) begin
        checks++;
        if (skp_pending !== 2'd1 || mux_sel !== 1'b0) begin
          failures++;
          $display("FAIL interval_pending: pending=%0d mux=%b expected pending=1 mux=0", skp_pending, mux_sel);
        end
      end
      if (i == 16) begin
        checks++;
        if (mux_sel !== 1'b1 || hold_fifo !== 1'b1 || os_type !== OS_SKP) begin
          failures++;
          $display("FAIL interval_hold: mux=%b hold=%b type=%0d expected 1 1 %0d", mux_sel, hold_fifo, os_type, OS_SKP);
        end
      end
      if (i == 22) begin
        checks++;
        if (mux_sel !== 1'b0 || skp_pending !== 2'd0 || os_type !== 3'd0) begin
          failures++;
          $display("FAIL interval_return: mux=%b pending=%0d type=%0d expected 0 0 0", mux_sel, skp_pending, os_type);
        end
      end
    end
    checks++;
    if (first !== 17 || second !== 33) begin
      failures++;
      $display("FAIL interval_starts: got %0d,%0d expected 17,33", first, second);
    end
  endtask

  task automatic test_pkt_hold();
    int early = 0, starts = 0;
    bit mux_drop = 1'b0;
    apply_reset();
    enable = 1'b1;
    fin_delay = 2;
    for (int i = 0; i < 79; i++) begin
      step_cycle();
      if (i < 65 && os_start) early++;
      if (i >= 65 && os_start) starts++;
      if (i >= 65 && i <= 74 && !mux_sel) mux_drop = 1'b1;
      if (i == 10) pkt_active = 1'b1;
      if (i == 64) begin
        checks++;
        if (skp_pending !== 2'd3 || skp_overflow !== 1'b1) begin
          failures++;
          $display("FAIL pkt_saturate: pending=%0d ovf=%b expected 3 1", skp_pending, skp_overflow);
        end
        pkt_active = 1'b0;
      end
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL pkt_no_split: starts during packet=%0d expected 0", early);
    end
    checks++;
    if (starts !== 3 || mux_drop) begin
      failures++;
      $display("FAIL pkt_b2b: starts=%0d mux_drop=%b expected 3 0", starts, mux_drop);
    end
  endtask

  task automatic test_busy();
    int first = -1;
    bit hold_drop = 1'b0;
    apply_reset();
    enable = 1'b1;
    os_busy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step_cycle();
      if (os_start && first < 0) first = i;
      if (i >= 16 && i <= 21 && !hold_fifo) hold_drop = 1'b1;
      if (i == 20) os_busy = 1'b0;
    end
    checks++;
    if (first !== 21) begin
      failures++;
      $display("FAIL busy_delay: first start=%0d expected 21", first);
    end
    checks++;
    if (hold_drop) begin
      failures++;
      $display("FAIL busy_hold: hold_fifo dropped=%b expected 0", hold_drop);
    end
  endtask

  task automatic test_due_collision();
    bit mux_drop = 1'b0;
    apply_reset();
    enable = 1'b1;
    fin_delay = 13;
    for (int i = 0; i < 34; i++) begin
      step_cycle();
      if (i >= 16 && i <= 33 && !mux_sel) mux_drop = 1'b1;
      if (i == 31) begin
        checks++;
        if (skp_pending !== 2'd1 || os_start !== 1'b1) begin
          failures++;
          $display("FAIL collision: pending=%0d start=%b expected 1 1", skp_pending, os_start);
        end
      end
    end
    checks++;
    if (mux_drop) begin
      failures++;
      $display("FAIL collision_mux: mux dropped=%b expected 0", mux_drop);
    end
  endtask

  task automatic test_enable_drop();
    int late = 0, first = -1;
    bit pend_seen = 1'b0;
    apply_reset();
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step_cycle();
      if (i > 17 && os_start) late++;
      if (i >= 22 && skp_pending !== 2'd0) pend_seen = 1'b1;
      if (i == 19) enable = 1'b0;
      if (i == 22) begin
        checks++;
        if (mux_sel !== 1'b0 || hold_fifo !== 1'b0) begin
          failures++;
          $display("FAIL drop_idle: mux=%b hold=%b expected 0 0", mux_sel, hold_fifo);
        end
      end
    end
    checks++;
    if (late !== 0 || pend_seen) begin
      failures++;
      $display("FAIL drop_quiet: late starts=%0d pending seen=%b expected 0 0", late, pend_seen);
    end
    enable = 1'b1;
    for (int j = 0; j < 30; j++) begin
      step_cycle();
      if (os_start && first < 0) first = j;
    end
    checks++;
    if (first !== N + 1) begin
      failures++;
      $display("FAIL drop_restart: first start=%0d expected %0d", first, N + 1);
    end
  endtask

  task automatic test_reset_mid();
    int first = -1;
    logic [8:0] obs;
    apply_reset();
    enable = 1'b1;
    os_busy = 1'b1;
    for (int i = 0; i < 18; i++) step_cycle();
    checks++;
    if (mux_sel !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre: mux=%b expected 1", mux_sel);
    end
    #2 reset_n = 1'b0;
    #1;
    obs = {os_start, os_type, mux_sel, hold_fifo, skp_pending, skp_overflow};
    checks++;
    if (obs !== 9'd0) begin
      failures++;
      $display("FAIL midreset_async: outputs=%b expected %b", obs, 9'd0);
    end
    @(negedge pclk);
    reset_n = 1'b1;
    os_busy = 1'b0;
    for (int j = 0; j < 30; j++) begin
      step_cycle();
      if (os_start && first < 0) first = j;
    end
    checks++;
    if (first !== N + 1) begin
      failures++;
      $display("FAIL midreset_restart: first start=%0d expected %0d", first, N + 1);
    end
  endtask

  task automatic test_random();
    int pa_left = 0;
    logic [8:0] obs, exp;
    apply_reset();
    rnd_mode = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      step_cycle();
      obs = {os_start, os_type, mux_sel, hold_fifo, skp_pending, skp_overflow};
      exp = {m_start, (m_owns ? OS_SKP : OS_NONE), m_owns, m_owns, 2'(m_pend), m_ovf};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random cycle %0d: outputs=%b expected=%b", c, obs, exp);
      end
      if ($urandom_range(0, 299) == 0) enable = !enable;
      if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      if (pa_left > 0) pa_left--;
      else if ($urandom_range(0, 19) == 0) pa_left = $urandom_range(1, 80);
      pkt_active = (pa_left > 0);
      os_busy = ($urandom_range(0, 3) == 0);
    end
    rnd_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_interval();
    test_pkt_hold();
    test_busy();
    test_due_collision();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
